p88_dump_tx: RTL

- Transmit-side counterpart to the P88 loader.
- On request, serialises a RAM region into the same P88 byte stream the loader consumes:
  - a C8 section record (segment, offset, two skip bytes, length, data);
  - an optional CA entry record (segment, offset).
- Sits beside the loader in the top level. It reads DRAM through the same address mux, holds the 8088/SlipStream in reset while dumping, and feeds a byte stream to the host upload path.

---
 rtl/p88_pkg.sv | 27 ++
 rtl/p88_dump_tx.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/p88_pkg.sv
// Purpose: shared P88 stream constants, dump FSM state type and seg:off helper.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package p88_pkg;

  localparam logic [7:0] P88_SECTION = 8'hC8;
  localparam logic [7:0] P88_ENTRY   = 8'hCA;
  localparam int         P88_HDR_LEN = 9;
  localparam int         P88_ENT_LEN = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_DATA,
    ST_ENT,
    ST_FIN
  } p88_state_t;

  // Real-mode style segment:offset to 20-bit linear address.
  function automatic logic [19:0] seg_off_to_lin(input logic [15:0] seg,
                                                 input logic [15:0] off);
    return ({4'b0, seg} << 4) + {4'b0, off};
  endfunction

endpackage

// File: rtl/p88_dump_tx.sv
// Purpose: serialise a RAM region into a P88 C8 section record plus optional CA entry record.
// Latency: header/entry bytes 1/cycle; data bytes one per RD_LAT+2 cycles, single read in flight.
// Backpressure: tx_valid/tx_ready; with tx_ready low the byte is held stable indefinitely.
//
// Ports: clk_sys/reset (sync, active high); start + src_seg/src_off/length/emit_entry/
// entry_seg/entry_off request; busy/done/hold_reset status; mem_addr/mem_rd/mem_q RAM
// read port; tx_data/tx_valid/tx_ready output byte stream.
module p88_dump_tx
  import p88_pkg::*;
#(
  parameter int ADDR_W = 18,
  parameter int RD_LAT = 1
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       src_seg,
  input  logic [15:0]       src_off,
  input  logic [15:0]       length,
  input  logic              emit_entry,
  input  logic [15:0]       entry_seg,
  input  logic [15:0]       entry_off,
  output logic              busy,
  output logic              done,
  output logic              hold_reset,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_q,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  p88_state_t        state, state_nx;
  logic [15:0]       seg_q, off_q, len_q, eseg_q, eoff_q;
  logic [15:0]       remaining;
  logic              emit_q;
  logic [3:0]        hdr_idx;
  logic [2:0]        ent_idx;
  logic [1:0]        wait_cnt;
  logic [ADDR_W-1:0] cur_addr;
  logic [7:0]        data_q;
  logic [7:0]        hdr_byte, ent_byte;
  logic              xfer;
  p88_state_t        tail_state;

  assign xfer       = tx_valid && tx_ready;
  assign tail_state = emit_q ? ST_ENT : ST_FIN;

  // Record byte selectors, driven from the latched request.
  always_comb begin
    hdr_byte = 8'h00;
    case (hdr_idx)
      4'd0:    hdr_byte = P88_SECTION;
      4'd1:    hdr_byte = seg_q[7:0];
      4'd2:    hdr_byte = seg_q[15:8];
      4'd3:    hdr_byte = off_q[7:0];
      4'd4:    hdr_byte = off_q[15:8];
      4'd7:    hdr_byte = len_q[7:0];
      4'd8:    hdr_byte = len_q[15:8];
      default: hdr_byte = 8'h00;  // indices 5,6 are the two skip bytes
    endcase
  end

  always_comb begin
    ent_byte = 8'h00;
    case (ent_idx)
      3'd0:    ent_byte = P88_ENTRY;
      3'd1:    ent_byte = eseg_q[7:0];
      3'd2:    ent_byte = eseg_q[15:8];
      3'd3:    ent_byte = eoff_q[7:0];
      3'd4:    ent_byte = eoff_q[15:8];
      default: ent_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:     if (start) state_nx = ST_HDR;
      ST_HDR:      if (xfer && hdr_idx == 4'(P88_HDR_LEN - 1))
                     state_nx = (remaining != 16'd0) ? ST_RD_ISSUE : tail_state;
      ST_RD_ISSUE: state_nx = ST_RD_WAIT;
      ST_RD_WAIT:  if (wait_cnt == 2'(RD_LAT - 1)) state_nx = ST_DATA;
      // remaining still holds the pre-decrement count here
      ST_DATA:     if (xfer) state_nx = (remaining != 16'd1) ? ST_RD_ISSUE : tail_state;
      ST_ENT:      if (xfer && ent_idx == 3'(P88_ENT_LEN - 1)) state_nx = ST_FIN;
      ST_FIN:      state_nx = ST_IDLE;
      default:     state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      seg_q     <= '0;
      off_q     <= '0;
      len_q     <= '0;
      eseg_q    <= '0;
      eoff_q    <= '0;
      emit_q    <= 1'b0;
      remaining <= '0;
      hdr_idx   <= '0;
      ent_idx   <= '0;
      wait_cnt  <= '0;
      cur_addr  <= '0;
      data_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          seg_q     <= src_seg;
          off_q     <= src_off;
          len_q     <= length;
          eseg_q    <= entry_seg;
          eoff_q    <= entry_off;
          emit_q    <= emit_entry;
          remaining <= length;
          hdr_idx   <= '0;
          ent_idx   <= '0;
          cur_addr  <= ADDR_W'(seg_off_to_lin(src_seg, src_off));
        end
        ST_HDR:      if (xfer) hdr_idx <= hdr_idx + 4'd1;
        ST_RD_ISSUE: wait_cnt <= '0;
        ST_RD_WAIT: begin
          // mem_q is only trusted on the last wait cycle
          if (wait_cnt == 2'(RD_LAT - 1)) data_q   <= mem_q;
          else                            wait_cnt <= wait_cnt + 2'd1;
        end
        ST_DATA: if (xfer) begin
          cur_addr  <= cur_addr + 1'b1;
          remaining <= remaining - 16'd1;
        end
        ST_ENT:  if (xfer) ent_idx <= ent_idx + 3'd1;
        default: ;
      endcase
    end
  end

  assign busy       = (state != ST_IDLE) && (state != ST_FIN);
  assign hold_reset = busy;
  assign done       = (state == ST_FIN);
  assign mem_rd     = (state == ST_RD_ISSUE);
  assign mem_addr   = cur_addr;
  assign tx_valid   = (state == ST_HDR) || (state == ST_DATA) || (state == ST_ENT);

  always_comb begin
    tx_data = 8'h00;
    case (state)
      ST_HDR:  tx_data = hdr_byte;
      ST_ENT:  tx_data = ent_byte;
      ST_DATA: tx_data = data_q;
      default: tx_data = 8'h00;
    endcase
  end

endmodule
